// File: rtl/fnd_pkg.sv
// Shared types and helpers for the FND scan controller: state encoding,
// digit indexing, and the nibble-select / leading-zero rules.
package fnd_pkg;

  localparam int FND_DIGITS = 4;
  localparam int DIGIT_W    = 2;
  localparam int WORD_W     = 16;

  typedef logic [DIGIT_W-1:0] digit_t;

  typedef enum logic {
    S_BLANK = 1'b0,
    S_ON    = 1'b1
  } fnd_state_e;

  function automatic logic [3:0] nibble_of(input logic [WORD_W-1:0] w, input digit_t k);
    return w[{k, 2'b00} +: 4];
  endfunction

  // Digit k is dark when it and every more-significant nibble are zero; digit 0 always shows.
  function automatic logic lz(input logic [WORD_W-1:0] w, input digit_t k, input logic en);
    logic [WORD_W-1:0] hi;
    hi = w >> {k, 2'b00};
    return en && (k != '0) && (hi == '0);
  endfunction

endpackage

// File: rtl/fnd_scan_controller_if.sv
// Display-word load port and decoder-facing scan outputs of the FND scan controller.
interface fnd_scan_controller_if;
  import fnd_pkg::*;

  // i_load is a one-cycle strobe with no back-pressure: the word on i_value is
  // captured on every cycle i_load is high and shown from the next frame boundary.
  logic [WORD_W-1:0] i_value;
  logic              i_load;
  logic              i_blank;
  digit_t            o_DigitSelect;
  logic              o_En;
  logic [3:0]        o_value;
  logic              o_frame_tick;
  fnd_state_e        dbg_state;

  modport master (
    output i_value, i_load, i_blank,
    input  o_DigitSelect, o_En, o_value, o_frame_tick, dbg_state
  );

  modport slave (
    input  i_value, i_load, i_blank,
    output o_DigitSelect, o_En, o_value, o_frame_tick, dbg_state
  );

endinterface

// File: rtl/fnd_prescaler.sv
// Phase counter: counts 0..limit_i-1, flags the terminal count and wraps to zero.
module fnd_prescaler #(
  parameter int CW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [CW-1:0] limit_i,
  output logic [CW-1:0] count_next_o,
  output logic          tc_o
);

  logic [CW-1:0] count_q, count_d;

  assign tc_o         = (count_q == limit_i - CW'(1));
  assign count_next_o = count_d;

  always_comb begin
    count_d = tc_o ? '0 : count_q + CW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) count_q <= '0;
    else       count_q <= count_d;
  end

endmodule

// File: rtl/fnd_scan_controller.sv
// Time-multiplexed 4-digit FND scanner with a blanking guard before each digit
// and display-word updates deferred to frame boundaries.
module fnd_scan_controller
  import fnd_pkg::*;
#(
  parameter int DIV_COUNT   = 100000,
  parameter int BLANK_COUNT = 1000,
  parameter bit LZ_BLANK    = 1'b1
) (
  input logic                  i_clk,
  input logic                  i_reset,
  fnd_scan_controller_if.slave bus
);

  localparam int MAX_COUNT = (DIV_COUNT > BLANK_COUNT) ? DIV_COUNT : BLANK_COUNT;
  localparam int CW        = $clog2(MAX_COUNT) + 1;

  localparam logic [CW-1:0] DIV_L      = CW'(DIV_COUNT);
  localparam logic [CW-1:0] BLANK_L    = CW'(BLANK_COUNT);
  localparam digit_t        LAST_DIGIT = digit_t'(FND_DIGITS - 1);

  fnd_state_e        state_q, state_d;
  digit_t            digit_q, digit_d;
  logic [WORD_W-1:0] disp_q, disp_d;
  logic [WORD_W-1:0] staged_q, staged_d;
  logic              pending_q, pending_d;
  logic              en_q, en_d;
  logic [3:0]        val_q, val_d;
  logic              tick_q, tick_d;

  logic [CW-1:0]     limit;
  logic [CW-1:0]     count_next;
  logic              tc;
  logic              boundary;

  assign limit = (state_q == S_ON) ? DIV_L : BLANK_L;

  fnd_prescaler #(.CW(CW)) u_prescaler (
    .clk_i        (i_clk),
    .rst_i        (i_reset),
    .limit_i      (limit),
    .count_next_o (count_next),
    .tc_o         (tc)
  );

  assign boundary = (state_q == S_ON) && tc && (digit_q == LAST_DIGIT);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= S_BLANK;
      digit_q   <= '0;
      disp_q    <= '0;
      staged_q  <= '0;
      pending_q <= 1'b0;
      en_q      <= 1'b1;
      val_q     <= '0;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      digit_q   <= digit_d;
      disp_q    <= disp_d;
      staged_q  <= staged_d;
      pending_q <= pending_d;
      en_q      <= en_d;
      val_q     <= val_d;
      tick_q    <= tick_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    digit_d   = digit_q;
    disp_d    = disp_q;
    staged_d  = staged_q;
    pending_d = pending_q;
    if (tc) begin
      if (state_q == S_BLANK) begin
        state_d = S_ON;
      end else begin
        state_d = S_BLANK;
        digit_d = digit_t'(digit_q + digit_t'(1));
      end
    end
    // A load on the boundary cycle bypasses staging and lands with the new frame.
    if (boundary) begin
      pending_d = 1'b0;
      if (bus.i_load)     disp_d = bus.i_value;
      else if (pending_q) disp_d = staged_q;
    end else if (bus.i_load) begin
      staged_d  = bus.i_value;
      pending_d = 1'b1;
    end
  end

  // Outputs are computed from next-cycle state so they register on the same edge.
  // The frame tick looks one cycle ahead so it coincides with the boundary cycle.
  always_comb begin
    en_d   = 1'b1;
    val_d  = nibble_of(disp_d, digit_d);
    tick_d = 1'b0;
    if (state_d == S_ON) begin
      en_d   = bus.i_blank | lz(disp_d, digit_d, LZ_BLANK);
      tick_d = (digit_d == LAST_DIGIT) && (count_next == DIV_L - CW'(1));
    end
  end

  assign bus.o_DigitSelect = digit_q;
  assign bus.o_En          = en_q;
  assign bus.o_value       = val_q;
  assign bus.o_frame_tick  = tick_q;
  assign bus.dbg_state     = state_q;

endmodule
